sdram_ls_arbiter: RTL

// Shares the SDRAM controller's single load/store (ls) toggle-handshake port

---
 rtl/sdram_ls_pkg.sv | 14 +
 rtl/sdram_ls_arbiter_if.sv | 29 ++
 rtl/sdram_ls_arbiter_rr_pick.sv | 27 ++
 rtl/sdram_ls_arbiter.sv | 99 +++++++++
 4 files changed

// File: rtl/sdram_ls_pkg.sv
// Shared types for the SDRAM load/store port arbiter: FSM states and client ids.
package sdram_ls_pkg;

    typedef enum logic [1:0] {
        LS_SYNC,
        LS_IDLE,
        LS_WAIT
    } ls_arb_st_t;

    localparam int LS_CLI_ROM  = 0;
    localparam int LS_CLI_BKWR = 1;
    localparam int LS_CLI_BKRD = 2;

endpackage

// File: rtl/sdram_ls_arbiter_if.sv
// Client toggle-handshake bundle plus the SDRAM ls_* port; master = arbiter side.
interface sdram_ls_arbiter_if #(
    parameter int NCLI = 3,
    parameter int AW   = 25
);
    logic [NCLI-1:0]          cli_req;
    logic [NCLI-1:0]          cli_ack;
    logic [NCLI-1:0]          cli_we;
    logic [NCLI-1:0][AW-1:0]  cli_addr;
    logic [NCLI-1:0][31:0]    cli_din;
    logic [31:0]              cli_dout;
    logic [AW-1:0]            ls_addr;
    logic [31:0]              ls_din;
    logic                     ls_we_req;
    logic                     ls_we_ack;
    logic                     ls_rd_req;
    logic                     ls_rd_ack;
    logic [31:0]              ls_dout;

    modport master (
        input  cli_req, cli_we, cli_addr, cli_din, ls_we_ack, ls_rd_ack, ls_dout,
        output cli_ack, cli_dout, ls_addr, ls_din, ls_we_req, ls_rd_req
    );

    modport slave (
        output cli_req, cli_we, cli_addr, cli_din, ls_we_ack, ls_rd_ack, ls_dout,
        input  cli_ack, cli_dout, ls_addr, ls_din, ls_we_req, ls_rd_req
    );
endinterface

// File: rtl/sdram_ls_arbiter_rr_pick.sv
// Round-robin picker: first set request bit at or after ptr, wrapping at NCLI-1.
module rr_pick #(
    parameter  int NCLI = 3,
    localparam int IW   = $clog2(NCLI)
) (
    input  logic [NCLI-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            vld,
    output logic [IW-1:0]   idx
);
    int j;

    // Scan from farthest to nearest so the closest requester overwrites the rest.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        j   = 0;
        for (int k = NCLI - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NCLI) j = j - NCLI;
            if (req[j]) begin
                vld = 1'b1;
                idx = IW'(j);
            end
        end
    end
endmodule

// File: rtl/sdram_ls_arbiter.sv
// Shares the SDRAM single ls toggle port among NCLI clients, one transfer in flight,
// round-robin grant, with a per-transfer watchdog and sticky error flag.
module sdram_ls_arbiter
    import sdram_ls_pkg::*;
#(
    parameter  int NCLI    = 3,
    parameter  int AW      = 25,
    parameter  int TIMEOUT = 4095,
    localparam int IW      = $clog2(NCLI)
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    sdram_ls_arbiter_if.master   bus,
    output logic                 busy,
    output logic [IW-1:0]        grant,
    output logic                 err
);
    localparam int             WDW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LIM = WDW'(TIMEOUT);

    ls_arb_st_t      state;
    logic [IW-1:0]   rr_ptr;
    logic [WDW-1:0]  wd_cnt;
    logic [WDW-1:0]  wd_nxt;
    logic            cur_we;
    logic            req_snap;
    logic [NCLI-1:0] pend;
    logic            win_vld;
    logic [IW-1:0]   win;
    logic            done;
    logic            ls_synced;

    assign pend      = bus.cli_req ^ bus.cli_ack;
    assign wd_nxt    = wd_cnt + WDW'(1);
    assign ls_synced = (bus.ls_we_ack == bus.ls_we_req) && (bus.ls_rd_ack == bus.ls_rd_req);
    assign done      = cur_we ? (bus.ls_we_ack == bus.ls_we_req)
                              : (bus.ls_rd_ack == bus.ls_rd_req);

    rr_pick #(.NCLI(NCLI)) u_pick (
        .req (pend),
        .ptr (rr_ptr),
        .vld (win_vld),
        .idx (win)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state         <= LS_SYNC;
            bus.cli_ack   <= '0;
            bus.cli_dout  <= '0;
            bus.ls_addr   <= '0;
            bus.ls_din    <= '0;
            bus.ls_we_req <= 1'b0;
            bus.ls_rd_req <= 1'b0;
            busy          <= 1'b0;
            grant         <= '0;
            err           <= 1'b0;
            rr_ptr        <= '0;
            wd_cnt        <= '0;
            cur_we        <= 1'b0;
            req_snap      <= 1'b0;
        end else begin
            case (state)
                // SDRAM side may come out of reset later with stale ack levels.
                LS_SYNC: if (ls_synced) state <= LS_IDLE;

                LS_IDLE: if (win_vld) begin
                    bus.ls_addr <= bus.cli_addr[win];
                    bus.ls_din  <= bus.cli_din[win];
                    cur_we      <= bus.cli_we[win];
                    if (bus.cli_we[win]) bus.ls_we_req <= ~bus.ls_we_req;
                    else                 bus.ls_rd_req <= ~bus.ls_rd_req;
                    grant       <= win;
                    busy        <= 1'b1;
                    wd_cnt      <= '0;
                    req_snap    <= bus.cli_req[win];
                    state       <= LS_WAIT;
                end

                LS_WAIT: begin
                    // A second toggle from the owner would be lost: flag it, finish anyway.
                    if (bus.cli_req[grant] != req_snap) err <= 1'b1;
                    if (done) begin
                        if (!cur_we) bus.cli_dout <= bus.ls_dout;
                        bus.cli_ack[grant] <= ~bus.cli_ack[grant];
                        busy   <= 1'b0;
                        rr_ptr <= (grant == IW'(NCLI - 1)) ? '0 : grant + IW'(1);
                        state  <= LS_IDLE;
                    end else if (wd_cnt != WD_LIM) begin
                        wd_cnt <= wd_nxt;
                        if (TIMEOUT != 0 && wd_nxt == WD_LIM) err <= 1'b1;
                    end
                end

                default: state <= LS_SYNC;
            endcase
        end
    end
endmodule
